chunk_serializer: RTL and testbench

Downstream consumer for chunk-array producers. Accepts one frame of `CHUNKS` 11-bit chunks as an unpacked array port, snapshots it on a valid/ready handshake, and emits the chunks one per accepted beat on an 11-bit valid/ready stream, index 0 first. Sits between a producer's `data [CHUNKS]` output and any narrow downstream sink, such as a checker, FIFO or monitor.

---
 rtl/chunk_serializer.sv | 130 +++++++++++++
 tb/tb_chunk_serializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_serializer.sv
// chunk_serializer: snapshots a CHUNKS x 11-bit frame on in_valid/in_ready and streams it out, index 0 first.
// Optional: define CHUNK_SERIALIZER_PARITY_EN to add out_parity (even parity of out_chunk).

module chunk_snap_lane (
  input  logic        clock,
  input  logic        reset,
  input  logic        cap,
  input  logic [10:0] d,
  output logic [10:0] q
`ifdef CHUNK_SERIALIZER_PARITY_EN
  ,
  output logic        p
`endif
);
  always_ff @(posedge clock) begin
    if (reset)    q <= '0;
    else if (cap) q <= d;
  end

`ifdef CHUNK_SERIALIZER_PARITY_EN
  // parity is captured with the chunk so it never depends on the output mux
  always_ff @(posedge clock) begin
    if (reset)    p <= 1'b0;
    else if (cap) p <= ^d;
  end
`endif
endmodule

module chunk_serializer #(
  parameter  int CHUNKS = 5,
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      data [CHUNKS],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_chunk,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic [15:0]      frame_count
`ifdef CHUNK_SERIALIZER_PARITY_EN
  ,
  output logic             out_parity
`endif
);
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            idx;
  logic [15:0]                 fcnt;
  logic [CHUNKS-1:0][10:0]     snap;
  logic                        cap, acc, done;

  assign cap  = (state == IDLE) && in_valid;
  assign acc  = (state == SEND) && out_ready;
  assign done = acc && (idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SEND;
      SEND:    if (done)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == SEND);
    out_last  = (state == SEND) && (idx == LAST_IDX);
  end

  always_ff @(posedge clock) begin
    if (reset)             idx <= '0;
    else if (cap)          idx <= '0;
    else if (acc && !done) idx <= idx + IDX_W'(1);
  end

  // modular counter, wraps silently
  always_ff @(posedge clock) begin
    if (reset)     fcnt <= '0;
    else if (done) fcnt <= fcnt + 16'd1;
  end

  assign frame_count = fcnt;
  assign out_index   = idx;

`ifdef CHUNK_SERIALIZER_PARITY_EN
  logic [CHUNKS-1:0] par;
`endif

  for (genvar i = 0; i < CHUNKS; i++) begin : g_lane
    chunk_snap_lane u_lane (
      .clock (clock),
      .reset (reset),
      .cap   (cap),
      .d     (data[i]),
      .q     (snap[i])
`ifdef CHUNK_SERIALIZER_PARITY_EN
      ,
      .p     (par[i])
`endif
    );
  end

  // output is a register mux only; data never reaches out_* combinationally
  always_comb begin
    out_chunk = '0;
    for (int i = 0; i < CHUNKS; i++)
      if (idx == IDX_W'(i)) out_chunk = snap[i];
  end

`ifdef CHUNK_SERIALIZER_PARITY_EN
  always_comb begin
    out_parity = 1'b0;
    for (int i = 0; i < CHUNKS; i++)
      if (idx == IDX_W'(i)) out_parity = par[i];
  end
`endif
endmodule

// File: tb/tb_chunk_serializer.sv
// Scoreboard bench for chunk_serializer: a CHUNKS=5 instance plus a CHUNKS=1 instance fed by an array slice.
module tb_chunk_serializer;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [10:0] da [5];
  logic [10:0] out_chunk;
  logic [2:0]  out_index;
  logic [15:0] frame_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [10:0] arr [8];
  logic [10:0] b_out_chunk;
  logic [0:0]  b_out_index;
  logic [15:0] b_frame_count;
`ifdef CHUNK_SERIALIZER_PARITY_EN
  logic        out_parity, b_out_parity;
`endif

  always #5 clock = ~clock;

  chunk_serializer #(.CHUNKS(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .data(da),
    .out_valid(out_valid), .out_ready(out_ready), .out_chunk(out_chunk), .out_index(out_index),
    .out_last(out_last), .frame_count(frame_count)
`ifdef CHUNK_SERIALIZER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  chunk_serializer #(.CHUNKS(1)) dut_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .data(arr[3:3]),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chunk(b_out_chunk), .out_index(b_out_index),
    .out_last(b_out_last), .frame_count(b_frame_count)
`ifdef CHUNK_SERIALIZER_PARITY_EN
    , .out_parity(b_out_parity)
`endif
  );

  typedef struct {logic [10:0] chunk; int idx; logic last;} beat_t;
  beat_t       qa[$];
  logic [10:0] qb[$];
  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, ncap = 0, last_cap = 0;
  logic [15:0] exp_fc = 0;
  logic        spc_en = 0, spc_prev = 0, pre_fc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (!in_ready && n < maxc) begin step(); n++; end
    chk("idle_timeout", {31'd0, in_ready}, 1);
  endtask

  // scoreboard for the 5-chunk instance
  always @(negedge clock) begin
    beat_t e;
    cyc++;
    if (reset) begin
      qa.delete();
      exp_fc = '0;
      spc_prev = 1'b0;
    end else begin
      if (pre_fc) exp_fc = 16'hFFFF;
      chk("frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
      if (out_valid) begin
        if (qa.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          e = qa[0];
          chk("chunk", {21'd0, out_chunk}, {21'd0, e.chunk});
          chk("index", {29'd0, out_index}, e.idx);
          chk("last",  {31'd0, out_last}, {31'd0, e.last});
`ifdef CHUNK_SERIALIZER_PARITY_EN
          chk("parity", {31'd0, out_parity}, {31'd0, ^e.chunk});
`endif
          if (out_ready) begin
            void'(qa.pop_front());
            if (e.last) exp_fc = exp_fc + 16'd1;
          end
        end
      end else chk("last_idle", {31'd0, out_last}, 0);
      if (in_valid && in_ready) begin
        for (int i = 0; i < 5; i++) qa.push_back('{da[i], i, i == 4});
        if (spc_en) begin
          if (spc_prev) chk("frame_spacing", cyc - last_cap, 6);
          spc_prev = 1'b1;
        end else spc_prev = 1'b0;
        last_cap = cyc;
        ncap++;
      end
    end
  end

  // scoreboard for the single-chunk slice instance
  always @(negedge clock) begin
    if (reset) qb.delete();
    else begin
      if (b_out_valid) begin
        if (qb.size() == 0) chk("b_spurious_beat", 1, 0);
        else begin
          chk("b_chunk", {21'd0, b_out_chunk}, {21'd0, qb[0]});
          chk("b_index", {31'd0, b_out_index}, 0);
          chk("b_last",  {31'd0, b_out_last}, 1);
`ifdef CHUNK_SERIALIZER_PARITY_EN
          chk("b_parity", {31'd0, b_out_parity}, {31'd0, ^qb[0]});
`endif
          if (b_out_ready) void'(qb.pop_front());
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back(arr[3]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bp;
    int n, base;
    bp = 4'b1001;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) da[i] = '0;
    for (int i = 0; i < 8; i++) arr[i] = '0;
    step(); step();
    chk("rst_in_ready",  {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_chunk", {21'd0, out_chunk}, 0);
    chk("rst_out_index", {29'd0, out_index}, 0);
    chk("rst_out_last",  {31'd0, out_last}, 0);
    chk("rst_frame_count", {16'd0, frame_count}, 0);
`ifdef CHUNK_SERIALIZER_PARITY_EN
    chk("rst_out_parity", {31'd0, out_parity}, 0);
`endif
    reset = 1'b0;

    // basic frame
    da[0] = 11'h001; da[1] = 11'h002; da[2] = 11'h004; da[3] = 11'h008; da[4] = 11'h010;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("lat_out_valid", {31'd0, out_valid}, 1);
    chk("lat_index", {29'd0, out_index}, 0);
    chk("send_in_ready", {31'd0, in_ready}, 0);
    repeat (4) step();
    chk("basic_last_idx", {29'd0, out_index}, 4);
    chk("basic_last", {31'd0, out_last}, 1);
    step();
    chk("basic_in_ready", {31'd0, in_ready}, 1);
    chk("basic_frame_count", {16'd0, frame_count}, 1);

    // backpressure with data overwritten after capture
    da[0] = 11'h0A1; da[1] = 11'h1B2; da[2] = 11'h2C3; da[3] = 11'h3D4; da[4] = 11'h4E5;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) da[i] = 11'h7FF;
    n = 0;
    while (!in_ready && n < 40) begin out_ready = bp[n % 4]; step(); n++; end
    out_ready = 1'b1;
    chk("bp_idle", {31'd0, in_ready}, 1);
    chk("bp_frame_count", {16'd0, frame_count}, 2);

    // reset mid-frame after beat 2
    da[0] = 11'h011; da[1] = 11'h022; da[2] = 11'h033; da[3] = 11'h044; da[4] = 11'h055;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("mrst_out_valid", {31'd0, out_valid}, 0);
    chk("mrst_in_ready", {31'd0, in_ready}, 1);
    chk("mrst_frame_count", {16'd0, frame_count}, 0);
    da[0] = 11'h101; da[1] = 11'h202; da[2] = 11'h303; da[3] = 11'h404; da[4] = 11'h505;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("mrst_first_index", {29'd0, out_index}, 0);
    wait_idle(20);

    // single-chunk slice instance
    arr[3] = 11'h555; b_in_valid = 1'b1; step(); b_in_valid = 1'b0;
    chk("b_valid", {31'd0, b_out_valid}, 1);
    chk("b_555", {21'd0, b_out_chunk}, 11'h555);
`ifdef CHUNK_SERIALIZER_PARITY_EN
    chk("b_par_555", {31'd0, b_out_parity}, 0);
`endif
    step();
    chk("b_fc1", {16'd0, b_frame_count}, 1);
    arr[3] = 11'h554; b_in_valid = 1'b1; step(); b_in_valid = 1'b0;
    chk("b_554", {21'd0, b_out_chunk}, 11'h554);
`ifdef CHUNK_SERIALIZER_PARITY_EN
    chk("b_par_554", {31'd0, b_out_parity}, 1);
`endif
    step();
    chk("b_fc2", {16'd0, b_frame_count}, 2);
    chk("b_in_ready", {31'd0, b_in_ready}, 1);

    // in_valid held high, new pattern every cycle
    reset = 1'b1; step(); reset = 1'b0;
    base = ncap; spc_en = 1'b1; in_valid = 1'b1; n = 0;
    while (ncap - base < 10 && n < 200) begin
      for (int i = 0; i < 5; i++) da[i] = 11'(n * 7 + i * 3 + 1);
      step(); n++;
    end
    in_valid = 1'b0; spc_en = 1'b0;
    chk("cont_captures", ncap - base, 10);
    wait_idle(20);
    chk("cont_frame_count", {16'd0, frame_count}, 10);

    // wrap: preload the counter then complete one frame
    @(posedge clock); #2;
    dut.fcnt = 16'hFFFF; pre_fc = 1'b1;
    step(); pre_fc = 1'b0;
    da[0] = 11'h7A0; da[1] = 11'h0B1; da[2] = 11'h1C2; da[3] = 11'h2D3; da[4] = 11'h3E4;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("pre_wrap_fc", {16'd0, frame_count}, 16'hFFFF);
    wait_idle(20);
    chk("wrap_frame_count", {16'd0, frame_count}, 0);

    step();
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
